// File: rtl/control_sequencer.sv
// Hardwired multi-cycle control unit for the Mini-SRC datapath.
// Fetch runs T0-T2, execute runs T3-T7; memory waits stall T1, T6 (ld) and T7 (st).
module control_sequencer #(
  parameter logic [4:0] ADD_OP = 5'b00011
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic [31:0] in_ir,
  input  logic        in_mem_ready,
  output logic        out_gra,
  output logic        out_grb,
  output logic        out_grc,
  output logic        out_read,
  output logic        out_write,
  output logic        out_base_addr_read,
  output logic        out_pc_out,
  output logic        out_pc_in,
  output logic        out_inc_pc,
  output logic        out_mar_in,
  output logic        out_mdr_in,
  output logic        out_mdr_out,
  output logic        out_mem_read,
  output logic        out_mem_write,
  output logic        out_ir_in,
  output logic        out_y_in,
  output logic        out_z_in,
  output logic        out_z_out,
  output logic        out_c_out,
  output logic [4:0]  out_alu_op,
  output logic        out_run
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t state, state_next;

  logic [4:0] opcode;
  logic       is_ld, is_ldi, is_st, is_addr;
  logic       is_alu_reg, is_alu_imm, is_alu;
  logic       is_jr, is_jal, is_halt;
  logic       unused_ir;

  assign opcode     = in_ir[31:27];
  assign unused_ir  = ^in_ir[26:0];
  assign is_ld      = (opcode == 5'b00000);
  assign is_ldi     = (opcode == 5'b00001);
  assign is_st      = (opcode == 5'b00010);
  assign is_addr    = is_ld | is_ldi | is_st;
  assign is_alu_reg = (opcode >= 5'b00011) && (opcode <= 5'b01010);
  assign is_alu_imm = (opcode >= 5'b01011) && (opcode <= 5'b01101);
  assign is_alu     = is_alu_reg | is_alu_imm;
  assign is_jr      = (opcode == 5'b10011);
  assign is_jal     = (opcode == 5'b10100);
  assign is_halt    = (opcode == 5'b11010);

  always_ff @(posedge in_clk) begin
    if (in_rst) state <= S_RST;
    else        state <= state_next;
  end

  always_comb begin
    state_next         = state;
    out_gra            = 1'b0;
    out_grb            = 1'b0;
    out_grc            = 1'b0;
    out_read           = 1'b0;
    out_write          = 1'b0;
    out_base_addr_read = 1'b0;
    out_pc_out         = 1'b0;
    out_pc_in          = 1'b0;
    out_inc_pc         = 1'b0;
    out_mar_in         = 1'b0;
    out_mdr_in         = 1'b0;
    out_mdr_out        = 1'b0;
    out_mem_read       = 1'b0;
    out_mem_write      = 1'b0;
    out_ir_in          = 1'b0;
    out_y_in           = 1'b0;
    out_z_in           = 1'b0;
    out_z_out          = 1'b0;
    out_c_out          = 1'b0;
    out_alu_op         = '0;
    out_run            = 1'b0;

    unique case (state)
      S_RST: state_next = S_T0;
      S_T0: begin
        out_run    = 1'b1;
        out_pc_out = 1'b1;
        out_mar_in = 1'b1;
        out_inc_pc = 1'b1;
        state_next = S_T1;
      end
      S_T1: begin
        out_run      = 1'b1;
        out_mem_read = 1'b1;
        out_mdr_in   = 1'b1;
        if (in_mem_ready) state_next = S_T2;
      end
      S_T2: begin
        out_run     = 1'b1;
        out_mdr_out = 1'b1;
        out_ir_in   = 1'b1;
        state_next  = S_T3;
      end
      S_T3: begin
        out_run    = 1'b1;
        state_next = S_T0;
        if (is_addr) begin
          // Base-address read makes R0 contribute zero, so ld/ldi/st compute rb+C.
          out_grb            = 1'b1;
          out_base_addr_read = 1'b1;
          out_y_in           = 1'b1;
          state_next         = S_T4;
        end else if (is_alu) begin
          out_grb    = 1'b1;
          out_read   = 1'b1;
          out_y_in   = 1'b1;
          state_next = S_T4;
        end else if (is_jr) begin
          out_gra   = 1'b1;
          out_read  = 1'b1;
          out_pc_in = 1'b1;
        end else if (is_jal) begin
          out_pc_out = 1'b1;
          out_grb    = 1'b1;
          out_write  = 1'b1;
          state_next = S_T4;
        end else if (is_halt) begin
          state_next = S_HALT;
        end
      end
      S_T4: begin
        out_run    = 1'b1;
        state_next = S_T0;
        if (is_alu_reg) begin
          out_grc    = 1'b1;
          out_read   = 1'b1;
          out_z_in   = 1'b1;
          out_alu_op = opcode;
          state_next = S_T5;
        end else if (is_alu_imm) begin
          out_c_out  = 1'b1;
          out_z_in   = 1'b1;
          out_alu_op = opcode;
          state_next = S_T5;
        end else if (is_addr) begin
          out_c_out  = 1'b1;
          out_z_in   = 1'b1;
          out_alu_op = ADD_OP;
          state_next = S_T5;
        end else if (is_jal) begin
          out_gra   = 1'b1;
          out_read  = 1'b1;
          out_pc_in = 1'b1;
        end
      end
      S_T5: begin
        out_run    = 1'b1;
        out_z_out  = 1'b1;
        state_next = S_T0;
        if (is_ld || is_st) begin
          out_mar_in = 1'b1;
          state_next = S_T6;
        end else begin
          out_gra   = 1'b1;
          out_write = 1'b1;
        end
      end
      S_T6: begin
        out_run    = 1'b1;
        out_mdr_in = 1'b1;
        if (is_st) begin
          out_gra    = 1'b1;
          out_read   = 1'b1;
          state_next = S_T7;
        end else begin
          out_mem_read = 1'b1;
          if (in_mem_ready) state_next = S_T7;
        end
      end
      S_T7: begin
        out_run = 1'b1;
        if (is_st) begin
          out_mem_write = 1'b1;
          if (in_mem_ready) state_next = S_T0;
        end else begin
          out_mdr_out = 1'b1;
          out_gra     = 1'b1;
          out_write   = 1'b1;
          state_next  = S_T0;
        end
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_RST;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: expected per-cycle strobe vectors are
// queued alongside the ready stimulus and compared as the DUT steps.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ir;
  logic        ready;
  logic gra, grb, grc, rd, wr, bar, pco, pci, inc, mari, mdri, mdro;
  logic mrd, mwr, iri, yi, zi, zo, co, run;
  logic [4:0] alu_op;
  logic [24:0] outv;

  int errors = 0;
  int checks = 0;

  logic [24:0] sb[$];
  logic        rq[$];

  localparam logic [24:0] RUN  = 25'h1;
  localparam logic [24:0] GRA  = 25'h1 << 6;
  localparam logic [24:0] GRB  = 25'h1 << 7;
  localparam logic [24:0] GRC  = 25'h1 << 8;
  localparam logic [24:0] RD   = 25'h1 << 9;
  localparam logic [24:0] WR   = 25'h1 << 10;
  localparam logic [24:0] BAR  = 25'h1 << 11;
  localparam logic [24:0] PCO  = 25'h1 << 12;
  localparam logic [24:0] PCI  = 25'h1 << 13;
  localparam logic [24:0] INC  = 25'h1 << 14;
  localparam logic [24:0] MARI = 25'h1 << 15;
  localparam logic [24:0] MDRI = 25'h1 << 16;
  localparam logic [24:0] MDRO = 25'h1 << 17;
  localparam logic [24:0] MRD  = 25'h1 << 18;
  localparam logic [24:0] MWR  = 25'h1 << 19;
  localparam logic [24:0] IRI  = 25'h1 << 20;
  localparam logic [24:0] YI   = 25'h1 << 21;
  localparam logic [24:0] ZI   = 25'h1 << 22;
  localparam logic [24:0] ZO   = 25'h1 << 23;
  localparam logic [24:0] CO   = 25'h1 << 24;
  localparam logic [24:0] ST0  = PCO | MARI | INC | RUN;
  localparam logic [24:0] ST1  = MRD | MDRI | RUN;
  localparam logic [24:0] ST2  = MDRO | IRI | RUN;

  function automatic logic [24:0] alu(input logic [4:0] op);
    return {19'b0, op, 1'b0};
  endfunction

  task automatic push(input logic [24:0] e, input logic r);
    sb.push_back(e);
    rq.push_back(r);
  endtask

  // Fetch from T0 with ready high throughout; ends with the DUT in T2.
  task automatic push_fetch();
    push(ST1, 1'b1);
    push(ST2, 1'b1);
  endtask

  control_sequencer #(.ADD_OP(5'b00011)) dut (
    .in_clk(clk), .in_rst(rst), .in_ir(ir), .in_mem_ready(ready),
    .out_gra(gra), .out_grb(grb), .out_grc(grc), .out_read(rd), .out_write(wr),
    .out_base_addr_read(bar), .out_pc_out(pco), .out_pc_in(pci), .out_inc_pc(inc),
    .out_mar_in(mari), .out_mdr_in(mdri), .out_mdr_out(mdro),
    .out_mem_read(mrd), .out_mem_write(mwr), .out_ir_in(iri), .out_y_in(yi),
    .out_z_in(zi), .out_z_out(zo), .out_c_out(co), .out_alu_op(alu_op), .out_run(run)
  );

  assign outv = {co, zo, zi, yi, iri, mwr, mrd, mdro, mdri, mari, inc, pci, pco,
                 bar, wr, rd, grc, grb, gra, alu_op, run};

  always #5 clk = ~clk;

  task automatic test_reset();
    logic [24:0] e;
    rst = 1'b1; ready = 1'b1; ir = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (outv !== 25'h0) begin
        errors++; $display("FAIL reset cycle %0d: got %h want %h", i, outv, 25'h0);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (outv !== 25'h0) begin
      errors++; $display("FAIL reset_release_rst: got %h want %h", outv, 25'h0);
    end
    push(ST0, 1'b1);
    for (int n = 0; sb.size() > 0; n++) begin
      ready = rq.pop_front();
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if (outv !== e) begin
        errors++; $display("FAIL reset_to_t0 step %0d: got %h want %h", n, outv, e);
      end
    end
  endtask

  task automatic test_add();
    logic [24:0] e;
    ir = 32'h18000000;
    push_fetch();
    push(GRB | RD | YI | RUN, 1'b1);
    push(GRC | RD | ZI | alu(5'b00011) | RUN, 1'b1);
    push(ZO | GRA | WR | RUN, 1'b1);
    push(ST0, 1'b1);
    for (int n = 0; sb.size() > 0; n++) begin
      ready = rq.pop_front();
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if (outv !== e) begin
        errors++; $display("FAIL add step %0d: got %h want %h", n, outv, e);
      end
    end
  endtask

  task automatic test_immediates();
    logic [24:0] e;
    // addi-class opcode 01011, then ldi
    ir = 32'h58000000;
    push_fetch();
    push(GRB | RD | YI | RUN, 1'b1);
    push(CO | ZI | alu(5'b01011) | RUN, 1'b1);
    push(ZO | GRA | WR | RUN, 1'b1);
    push(ST0, 1'b1);
    for (int n = 0; sb.size() > 0; n++) begin
      ready = rq.pop_front();
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if (outv !== e) begin
        errors++; $display("FAIL alu_imm step %0d: got %h want %h", n, outv, e);
      end
    end
    ir = 32'h08000000;
    push_fetch();
    push(GRB | BAR | YI | RUN, 1'b1);
    push(CO | ZI | alu(5'b00011) | RUN, 1'b1);
    push(ZO | GRA | WR | RUN, 1'b1);
    push(ST0, 1'b1);
    for (int n = 0; sb.size() > 0; n++) begin
      ready = rq.pop_front();
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if (outv !== e) begin
        errors++; $display("FAIL ldi step %0d: got %h want %h", n, outv, e);
      end
    end
  endtask

  task automatic test_ld_wait();
    logic [24:0] e;
    ir = 32'h00000000;
    push_fetch();
    push(GRB | BAR | YI | RUN, 1'b1);
    push(CO | ZI | alu(5'b00011) | RUN, 1'b1);
    push(ZO | MARI | RUN, 1'b1);
    push(MRD | MDRI | RUN, 1'b1);
    for (int i = 0; i < 3; i++) push(MRD | MDRI | RUN, 1'b0);
    push(MDRO | GRA | WR | RUN, 1'b1);
    push(ST0, 1'b1);
    for (int n = 0; sb.size() > 0; n++) begin
      ready = rq.pop_front();
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if (outv !== e) begin
        errors++; $display("FAIL ld_wait step %0d: got %h want %h", n, outv, e);
      end
    end
  endtask

  task automatic test_st_wait();
    logic [24:0] e;
    ir = 32'h10000000;
    // one extra T1 cycle from a late fetch ready
    push(ST1, 1'b1);
    push(ST1, 1'b0);
    push(ST2, 1'b1);
    push(GRB | BAR | YI | RUN, 1'b1);
    push(CO | ZI | alu(5'b00011) | RUN, 1'b1);
    push(ZO | MARI | RUN, 1'b1);
    push(GRA | RD | MDRI | RUN, 1'b1);
    push(MWR | RUN, 1'b0);
    push(MWR | RUN, 1'b0);
    push(MWR | RUN, 1'b0);
    push(ST0, 1'b1);
    for (int n = 0; sb.size() > 0; n++) begin
      ready = rq.pop_front();
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if (outv !== e) begin
        errors++; $display("FAIL st_wait step %0d: got %h want %h", n, outv, e);
      end
    end
  endtask

  task automatic test_jumps();
    logic [24:0] e;
    ir = 32'hA0000000;
    push_fetch();
    push(PCO | GRB | WR | RUN, 1'b1);
    push(GRA | RD | PCI | RUN, 1'b1);
    push(ST0, 1'b1);
    for (int n = 0; sb.size() > 0; n++) begin
      ready = rq.pop_front();
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if (outv !== e) begin
        errors++; $display("FAIL jal step %0d: got %h want %h", n, outv, e);
      end
    end
    ir = 32'h98000000;
    push_fetch();
    push(GRA | RD | PCI | RUN, 1'b1);
    push(ST0, 1'b1);
    for (int n = 0; sb.size() > 0; n++) begin
      ready = rq.pop_front();
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if (outv !== e) begin
        errors++; $display("FAIL jr step %0d: got %h want %h", n, outv, e);
      end
    end
  endtask

  task automatic test_nop();
    logic [24:0] e;
    // 11111 is undefined and must behave like nop
    ir = 32'hF8000000;
    push_fetch();
    push(RUN, 1'b1);
    push(ST0, 1'b1);
    for (int n = 0; sb.size() > 0; n++) begin
      ready = rq.pop_front();
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if (outv !== e) begin
        errors++; $display("FAIL nop step %0d: got %h want %h", n, outv, e);
      end
    end
  endtask

  task automatic test_reset_mid_ld();
    logic [24:0] e;
    ir = 32'h00000000;
    push_fetch();
    push(GRB | BAR | YI | RUN, 1'b1);
    push(CO | ZI | alu(5'b00011) | RUN, 1'b1);
    push(ZO | MARI | RUN, 1'b1);
    push(MRD | MDRI | RUN, 1'b1);
    for (int n = 0; sb.size() > 0; n++) begin
      ready = rq.pop_front();
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if (outv !== e) begin
        errors++; $display("FAIL mid_reset_pre step %0d: got %h want %h", n, outv, e);
      end
    end
    rst = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (outv !== 25'h0) begin
      errors++; $display("FAIL mid_reset_abort: got %h want %h", outv, 25'h0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (outv !== ST0) begin
      errors++; $display("FAIL mid_reset_restart: got %h want %h", outv, ST0);
    end
  endtask

  task automatic test_halt();
    logic [24:0] e;
    ir = 32'hD0000000;
    push_fetch();
    push(RUN, 1'b1);
    for (int i = 0; i < 10; i++) push(25'h0, 1'($urandom_range(0, 1)));
    for (int n = 0; sb.size() > 0; n++) begin
      ready = rq.pop_front();
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if (outv !== e) begin
        errors++; $display("FAIL halt step %0d: got %h want %h", n, outv, e);
      end
    end
    rst = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (outv !== ST0) begin
      errors++; $display("FAIL halt_reset_restart: got %h want %h", outv, ST0);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_immediates();
    test_ld_wait();
    test_st_wait();
    test_jumps();
    test_nop();
    test_reset_mid_ld();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
